// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory pins around dmem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          P0_REQ;
  logic          P0_WE;
  logic [AW-1:0] P0_A;
  logic [DW-1:0] P0_WD;
  logic          P0_LOCK;
  logic          P0_GNT;
  logic          P0_RVALID;
  logic [DW-1:0] P0_RD;

  logic          P1_REQ;
  logic          P1_WE;
  logic [AW-1:0] P1_A;
  logic [DW-1:0] P1_WD;
  logic          P1_LOCK;
  logic          P1_GNT;
  logic          P1_RVALID;
  logic [DW-1:0] P1_RD;

  logic          MEM_WE;
  logic [AW-1:0] MEM_A;
  logic [DW-1:0] MEM_WD;
  logic [DW-1:0] MEM_RD;

  modport slave (
    input  P0_REQ, P0_WE, P0_A, P0_WD, P0_LOCK,
    input  P1_REQ, P1_WE, P1_A, P1_WD, P1_LOCK,
    output P0_GNT, P0_RVALID, P0_RD,
    output P1_GNT, P1_RVALID, P1_RD,
    output MEM_WE, MEM_A, MEM_WD,
    input  MEM_RD
  );

  modport master (
    output P0_REQ, P0_WE, P0_A, P0_WD, P0_LOCK,
    output P1_REQ, P1_WE, P1_A, P1_WD, P1_LOCK,
    input  P0_GNT, P0_RVALID, P0_RD,
    input  P1_GNT, P1_RVALID, P1_RD,
    input  MEM_WE, MEM_A, MEM_WD,
    output MEM_RD
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and the debug/loader (port 1), with per-port lock for read-modify-write sequences.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic          CLK,
  input logic          RST,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {StUnlocked, StLocked} lock_state_e;

  lock_state_e   state_q, state_d;
  logic          prio_q, prio_d;
  logic          owner_q, owner_d;
  logic [1:0]    req, lock, we, gnt;
  logic [1:0]    rvalid_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;

  assign req  = {bus.P1_REQ, bus.P0_REQ};
  assign lock = {bus.P1_LOCK, bus.P0_LOCK};
  assign we   = {bus.P1_WE, bus.P0_WE};

  // Grant is combinational; reset suppresses it so nothing reaches memory.
  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      if (state_q == StLocked) begin
        gnt[owner_q] = req[owner_q];
      end else if (req == 2'b11) begin
        gnt[prio_q] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    case (state_q)
      StUnlocked: begin
        if (gnt[0]) begin
          prio_d = 1'b1;
          if (lock[0]) begin
            state_d = StLocked;
            owner_d = 1'b0;
          end
        end else if (gnt[1]) begin
          prio_d = 1'b0;
          if (lock[1]) begin
            state_d = StLocked;
            owner_d = 1'b1;
          end
        end
      end
      StLocked: begin
        // Release on the owner's LOCK dropping, granted or not.
        if (!lock[owner_q]) begin
          state_d = StUnlocked;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StUnlocked;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid_q <= 2'b00;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      rvalid_q <= gnt & ~we;
      if (gnt[0] && !we[0]) rd0_q <= bus.MEM_RD;
      if (gnt[1] && !we[1]) rd1_q <= bus.MEM_RD;
    end
  end

  assign mem_a  = gnt[1] ? bus.P1_A  : bus.P0_A;
  assign mem_wd = gnt[1] ? bus.P1_WD : bus.P0_WD;

  assign bus.MEM_A     = mem_a;
  assign bus.MEM_WD    = mem_wd;
  assign bus.MEM_WE    = |(gnt & we);
  assign bus.P0_GNT    = gnt[0];
  assign bus.P1_GNT    = gnt[1];
  assign bus.P0_RVALID = rvalid_q[0];
  assign bus.P1_RVALID = rvalid_q[1];
  assign bus.P0_RD     = rd0_q;
  assign bus.P1_RD     = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.MEM_RD = mem[bus.MEM_A[7:0]];
  always @(posedge CLK) if (bus.MEM_WE) mem[bus.MEM_A[7:0]] <= bus.MEM_WD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic p0(input logic req, input logic wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic lk);
    bus.P0_REQ = req; bus.P0_WE = wr; bus.P0_A = a; bus.P0_WD = wd; bus.P0_LOCK = lk;
  endtask

  task automatic p1(input logic req, input logic wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic lk);
    bus.P1_REQ = req; bus.P1_WE = wr; bus.P1_A = a; bus.P1_WD = wd; bus.P1_LOCK = lk;
  endtask

  task automatic reset_pulse();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h5;
    mem[8'h08] = 32'hA;
    mem[8'h0C] = 32'h1;
    p0(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
    p1(1'b1, 1'b1, 32'h2004, 32'h99, 1'b0);

    // Reset: requests held high must not be granted.
    @(negedge CLK);
    check("rst_p0_gnt", 32'(bus.P0_GNT), 32'd0);
    check("rst_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    check("rst_mem_we", 32'(bus.MEM_WE), 32'd0);
    check("rst_p0_rvalid", 32'(bus.P0_RVALID), 32'd0);
    check("rst_p1_rd", bus.P1_RD, 32'd0);
    p0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();

    // Single read.
    RST = 1'b0;
    p0(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
    @(negedge CLK);
    check("rd_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    check("rd_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    check("rd_mem_a", bus.MEM_A, 32'h2000);
    check("rd_mem_we", 32'(bus.MEM_WE), 32'd0);
    tick();
    p0(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
    @(negedge CLK);
    check("rd_p0_rvalid", 32'(bus.P0_RVALID), 32'd1);
    check("rd_p0_rd", bus.P0_RD, 32'h5);
    check("rd_p1_rvalid", 32'(bus.P1_RVALID), 32'd0);
    check("rd_p1_rd", bus.P1_RD, 32'd0);
    tick();

    // Contention: grants alternate starting with port 0.
    reset_pulse();
    p0(1'b1, 1'b0, 32'h2008, 32'h0, 1'b0);
    p1(1'b1, 1'b0, 32'h200C, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("rr_p0_gnt%0d", i), 32'(bus.P0_GNT), 32'(i % 2 == 0));
      check($sformatf("rr_p1_gnt%0d", i), 32'(bus.P1_GNT), 32'(i % 2 == 1));
      if (i > 0) begin
        check($sformatf("rr_p0_rv%0d", i), 32'(bus.P0_RVALID), 32'(i % 2 == 1));
        check($sformatf("rr_p1_rv%0d", i), 32'(bus.P1_RVALID), 32'(i % 2 == 0));
      end
      if (i == 2) check("rr_p1_rd", bus.P1_RD, 32'h1);
      if (i == 3) check("rr_p0_rd", bus.P0_RD, 32'hA);
      tick();
    end
    p0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("rr_last_p1_rv", 32'(bus.P1_RVALID), 32'd1);
    check("rr_last_p0_rv", 32'(bus.P0_RVALID), 32'd0);
    tick();

    // Write on port 1, then read back on port 0.
    p1(1'b1, 1'b1, 32'h2000, 32'hDEAD, 1'b0);
    @(negedge CLK);
    check("wr_p1_gnt", 32'(bus.P1_GNT), 32'd1);
    check("wr_mem_we", 32'(bus.MEM_WE), 32'd1);
    check("wr_mem_a", bus.MEM_A, 32'h2000);
    check("wr_mem_wd", bus.MEM_WD, 32'hDEAD);
    tick();
    p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    p0(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
    @(negedge CLK);
    check("wr_rd_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    check("wr_rd_mem_we", 32'(bus.MEM_WE), 32'd0);
    check("wr_no_p1_rvalid", 32'(bus.P1_RVALID), 32'd0);
    tick();
    p0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    check("wr_rd_p0_rd", bus.P0_RD, 32'hDEAD);
    check("wr_rd_p0_rv", 32'(bus.P0_RVALID), 32'd1);
    tick();

    // Lock: port 0 read-modify-write while port 1 keeps requesting.
    reset_pulse();
    p0(1'b1, 1'b0, 32'h2000, 32'h0, 1'b1);
    p1(1'b1, 1'b0, 32'h200C, 32'h0, 1'b0);
    @(negedge CLK);
    check("lk_a_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    check("lk_a_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    tick();
    p0(1'b1, 1'b1, 32'h2000, 32'h6, 1'b1);
    @(negedge CLK);
    check("lk_b_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    check("lk_b_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    check("lk_b_mem_we", 32'(bus.MEM_WE), 32'd1);
    check("lk_b_p0_rd", bus.P0_RD, 32'hDEAD);
    tick();
    p0(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
    @(negedge CLK);
    check("lk_c_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    check("lk_c_mem_we", 32'(bus.MEM_WE), 32'd0);
    check("lk_c_mem", mem[8'h00], 32'h6);
    tick();
    @(negedge CLK);
    check("lk_d_p1_gnt", 32'(bus.P1_GNT), 32'd1);
    check("lk_d_mem_a", bus.MEM_A, 32'h200C);
    tick();

    // Reset mid-operation: P0 response due, P1 write pending.
    p0(1'b1, 1'b0, 32'h2008, 32'h0, 1'b0);
    p1(1'b1, 1'b1, 32'h2000, 32'h77, 1'b0);
    @(negedge CLK);
    check("mr_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    tick();
    RST = 1'b1;
    #1;
    check("mr_mem_we", 32'(bus.MEM_WE), 32'd0);
    check("mr_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    check("mr_p0_rvalid", 32'(bus.P0_RVALID), 32'd0);
    check("mr_p0_rd", bus.P0_RD, 32'd0);
    check("mr_p1_rd", bus.P1_RD, 32'd0);
    tick();
    check("mr_mem_kept", mem[8'h00], 32'h6);
    RST = 1'b0;
    p0(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
    @(negedge CLK);
    check("mr_post_p0_gnt", 32'(bus.P0_GNT), 32'd1);
    check("mr_post_p1_gnt", 32'(bus.P1_GNT), 32'd0);
    tick();
    p0(1'b0, 1'b0, 32'h2008, 32'h0, 1'b0);
    @(negedge CLK);
    check("mr_p1_gnt_next", 32'(bus.P1_GNT), 32'd1);
    check("mr_p1_mem_we", 32'(bus.MEM_WE), 32'd1);
    check("mr_post_p0_rd", bus.P0_RD, 32'h6);
    tick();
    p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Idle hold after a single read.
    p0(1'b1, 1'b0, 32'h2008, 32'h0, 1'b0);
    tick();
    p0(1'b0, 1'b0, 32'h2008, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("idle_rv%0d", i), 32'(bus.P0_RVALID), 32'(i == 0));
      check($sformatf("idle_rd%0d", i), bus.P0_RD, 32'hA);
      check($sformatf("idle_gnt%0d", i), 32'({bus.P1_GNT, bus.P0_GNT}), 32'd0);
      check($sformatf("idle_we%0d", i), 32'(bus.MEM_WE), 32'd0);
      tick();
    end
    check("idle_mem_a", bus.MEM_A, 32'h2008);
    check("mem_77", mem[8'h00], 32'h77);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
